// File: rtl/encoder_42_pipe.sv
// encoder_42_pipe: 4-to-2 priority encoder with a single-entry registered
// output stage, valid/ready handshakes on both sides, an active-low input
// enable, and a wrapping counter of completed output transfers.
// Optional build macro: ENC_ONEHOT_CHECK_EN. When it is defined, err is
// registered high alongside any code whose d had two or more bits set.
// When it is undefined, err is tied low.
module encoder_42_pipe #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [3:0]       d,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             a,
   output logic             b,
   output logic             none,
   output logic             err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] cnt
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t state_q, state_d;
   logic   accept;
   logic   out_xfer;
   logic   enc_a, enc_b, enc_none;

   // A new code may enter when the slot is free or is being drained this cycle
   assign in_ready  = !en && (state_q == EMPTY || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == FULL);
   assign out_xfer  = out_valid && out_ready;

   // Priority encode d; bit 3 wins
   always_comb begin
      enc_a    = 1'b0;
      enc_b    = 1'b0;
      enc_none = 1'b0;
      casez (d)
         4'b1???: begin enc_a = 1'b1; enc_b = 1'b1; end
         4'b01??: begin enc_a = 1'b1; enc_b = 1'b0; end
         4'b001?: begin enc_a = 1'b0; enc_b = 1'b1; end
         4'b0001: begin enc_a = 1'b0; enc_b = 1'b0; end
         default: enc_none = 1'b1;
      endcase
   end

   // Next-state: fill on accept, drain on out_ready, stay full on simultaneous refill
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL: begin
            if (accept)         state_d = FULL;
            else if (out_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Output code register: loads only on accept, so d is ignored otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a    <= 1'b0;
         b    <= 1'b0;
         none <= 1'b0;
      end else if (accept) begin
         a    <= enc_a;
         b    <= enc_b;
         none <= enc_none;
      end
   end

`ifdef ENC_ONEHOT_CHECK_EN
   logic multi_hot;

   // Two or more request lines set at once
   always_comb begin
      multi_hot = (d[3] & (d[2] | d[1] | d[0])) |
                  (d[2] & (d[1] | d[0])) |
                  (d[1] & d[0]);
   end

   // Error flag travels with its code
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      err <= 1'b0;
      else if (accept) err <= multi_hot;
   end
`else
   assign err = 1'b0;
`endif

   // Count completed output transfers; wraps naturally at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        cnt <= '0;
      else if (out_xfer) cnt <= cnt + 1'b1;
   end

endmodule

// File: tb/tb_encoder_42_pipe.sv
// Scoreboard bench for encoder_42_pipe: the stimulus pushes hand-computed
// codes {a,b,none,err}, and a negedge monitor pops and compares them on every
// output transfer. A second instance with CNT_W=2 shares the inputs so that
// the counter wrap can be observed.
module tb_encoder_42_pipe;

`ifdef ENC_ONEHOT_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] d;
   logic       in_valid;
   logic       out_ready;
   logic       in_ready, a, b, none, err, out_valid;
   logic [7:0] cnt;
   logic       in_ready2, a2, b2, none2, err2, out_valid2;
   logic [1:0] cnt2;

   logic [3:0] sb[$];
   int         total = 0;
   int         bad = 0;

   always #5 clk = ~clk;

   encoder_42_pipe #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .d(d), .in_valid(in_valid),
      .in_ready(in_ready), .a(a), .b(b), .none(none), .err(err),
      .out_valid(out_valid), .out_ready(out_ready), .cnt(cnt)
   );

   encoder_42_pipe #(.CNT_W(2)) dut_w2 (
      .clk(clk), .rst_n(rst_n), .en(en), .d(d), .in_valid(in_valid),
      .in_ready(in_ready2), .a(a2), .b(b2), .none(none2), .err(err2),
      .out_valid(out_valid2), .out_ready(out_ready), .cnt(cnt2)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, check in_ready before the edge, return at posedge+1
   task automatic send(input logic [3:0] dv, input logic iv, input logic env,
                       input logic ordy, input logic exp_rdy, input string nm);
      d = dv; in_valid = iv; en = env; out_ready = ordy;
      #1;
      chk({nm, "_in_ready"}, {31'b0, in_ready}, {31'b0, exp_rdy});
      @(posedge clk);
      #1;
   endtask

   // Monitor: every output transfer must match the oldest expected code
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got %b expected none queued", {a, b, none, err});
         end else begin
            logic [3:0] e;
            e = sb.pop_front();
            chk("code", {28'b0, a, b, none, err}, {28'b0, e});
            chk("code_w2", {28'b0, a2, b2, none2, err2}, {28'b0, e});
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; d = 4'b0; in_valid = 1'b0; out_ready = 1'b0;
      #3;
      chk("reset_out_valid", {31'b0, out_valid}, 0);
      chk("reset_code", {28'b0, a, b, none, err}, 0);
      chk("reset_cnt", {24'b0, cnt}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single transfer, 1-cycle latency, cnt one cycle after that
      sb.push_back(4'b1000);
      send(4'b0100, 1, 0, 1, 1, "t1_acc");
      chk("t1_out_valid", {31'b0, out_valid}, 1);
      chk("t1_cnt_before", {24'b0, cnt}, 0);
      send(4'b0000, 0, 0, 1, 1, "t1_drain");
      chk("t1_cnt", {24'b0, cnt}, 1);
      chk("t1_empty", {31'b0, out_valid}, 0);

      // Back-to-back sweep
      sb.push_back(4'b1100); send(4'b1000, 1, 0, 1, 1, "t2_1000");
      sb.push_back(4'b0100); send(4'b0010, 1, 0, 1, 1, "t2_0010");
      sb.push_back(4'b0000); send(4'b0001, 1, 0, 1, 1, "t2_0001");
      sb.push_back(4'b0010); send(4'b0000, 1, 0, 1, 1, "t2_0000");
      send(4'b0000, 0, 0, 1, 1, "t2_drain");
      chk("t2_cnt", {24'b0, cnt}, 5);          // 1 earlier + 4
      chk("t2_cnt_w2", {30'b0, cnt2}, 1);      // 5 mod 4

      // Backpressure: code held, in_ready low, then refill on release
      sb.push_back(4'b0000);
      send(4'b0001, 1, 0, 0, 1, "t3_acc");
      for (int i = 0; i < 3; i++) begin
         send(4'b1000, 1, 0, 0, 0, "t3_hold");
         chk("t3_hold_ab", {30'b0, a, b}, 0);
         chk("t3_hold_valid", {31'b0, out_valid}, 1);
      end
      sb.push_back(4'b1100);
      send(4'b1000, 1, 0, 1, 1, "t3_release");
      send(4'b0000, 0, 0, 1, 1, "t3_drain");
      chk("t3_cnt", {24'b0, cnt}, 7);

      // Disabled input ignores X, then a multi-hot value
      for (int i = 0; i < 2; i++) begin
         send(4'bxxxx, 1, 1, 1, 0, "t4_dis");
         chk("t4_dis_valid", {31'b0, out_valid}, 0);
      end
      sb.push_back({3'b010, ERR_EN});
      send(4'b0011, 1, 0, 1, 1, "t4_acc");
      send(4'b0000, 0, 0, 1, 1, "t4_drain");
      chk("t4_cnt", {24'b0, cnt}, 8);

      // Disable while full keeps the code and still completes the handshake
      sb.push_back(4'b1000);
      send(4'b0100, 1, 0, 0, 1, "t5_acc");
      send(4'b0000, 0, 1, 0, 0, "t5_en_hold");
      chk("t5_held_valid", {31'b0, out_valid}, 1);
      chk("t5_held_code", {28'b0, a, b, none, err}, 4'b1000);
      send(4'b0000, 0, 1, 1, 0, "t5_en_xfer");
      chk("t5_empty", {31'b0, out_valid}, 0);
      chk("t5_cnt", {24'b0, cnt}, 9);

      // Async reset while full discards the code immediately
      sb.push_back(4'b0100);
      send(4'b0010, 1, 0, 0, 1, "t6_acc");
      void'(sb.pop_back());
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {31'b0, out_valid}, 0);
      chk("t6_rst_cnt", {24'b0, cnt}, 0);
      chk("t6_rst_code", {28'b0, a, b, none, err}, 0);
      chk("t6_rst_cnt_w2", {30'b0, cnt2}, 0);
      d = 4'b1110; in_valid = 1'b1; en = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t6_rst_no_accept", {31'b0, out_valid}, 0);
      rst_n = 1'b1;
      sb.push_back(4'b1100); send(4'b1110, 1, 0, 1, 1, "t6_first");
      sb.push_back(4'b0000); send(4'b0001, 1, 0, 1, 1, "t6_0001");
      sb.push_back(4'b0100); send(4'b0010, 1, 0, 1, 1, "t6_0010");
      sb.push_back(4'b1000); send(4'b0100, 1, 0, 1, 1, "t6_0100");
      sb.push_back(4'b1100); send(4'b1000, 1, 0, 1, 1, "t6_1000");
      send(4'b0000, 0, 0, 1, 1, "t6_drain");
      chk("t6_cnt", {24'b0, cnt}, 5);
      chk("t6_cnt_w2_wrap", {30'b0, cnt2}, 1);   // 5 transfers with CNT_W=2

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
